// File: rtl/register_file_2r1w.sv
// Two-read / one-write register file with same-cycle write forwarding and a
// one-entry-per-cycle bulk-clear sweep. Define REGISTER_FILE_ZERO_REG_EN to hardwire register 0 to zero.
module register_file_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [ADDR_WIDTH-1:0] readRegA,
  input  logic [ADDR_WIDTH-1:0] readRegB,
  output logic [DATA_WIDTH-1:0] dataOutA,
  output logic [DATA_WIDTH-1:0] dataOutB,
  input  logic                  clearReq,
  output logic                  busy
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1);

`ifdef REGISTER_FILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   sweep_idx;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
  logic                    wr_ok;
  logic [DATA_WIDTH-1:0]   next_a;
  logic [DATA_WIDTH-1:0]   next_b;

  // Forwarding only applies to writes that will actually land this edge.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] idx,
    input logic                  wr_valid,
    input logic [ADDR_WIDTH-1:0] wr_idx,
    input logic [DATA_WIDTH-1:0] wr_data,
    input logic [DATA_WIDTH-1:0] stored
  );
    if (ZERO_REG && idx == '0)
      return '0;
    else if (wr_valid && idx == wr_idx)
      return wr_data;
    else
      return stored;
  endfunction

  always_comb begin
    wr_ok  = writeEnable && (state == IDLE) && !(ZERO_REG && writeReg == '0);
    next_a = read_port(readRegA, wr_ok, writeReg, dataIn, regs[readRegA]);
    next_b = read_port(readRegB, wr_ok, writeReg, dataIn, regs[readRegB]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sweep_idx <= '0;
      busy      <= 1'b0;
      dataOutA  <= '0;
      dataOutB  <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      dataOutA <= next_a;
      dataOutB <= next_b;
      case (state)
        IDLE: begin
          if (wr_ok)
            regs[writeReg] <= dataIn;
          if (clearReq) begin
            state     <= CLEAR;
            sweep_idx <= '0;
            busy      <= 1'b1;
          end
        end
        CLEAR: begin
          // Reads above see the pre-clear value of the entry swept this edge.
          regs[sweep_idx] <= '0;
          sweep_idx       <= sweep_idx + ONE_IDX;
          if (sweep_idx == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
Parametrised multi-port register file for the CPU datapath: two independent registered read ports and one write port.
- Width and depth are configurable.
- Same-cycle write-to-read forwarding.
- Sequenced bulk-clear engine that zeroes the file one entry per cycle, with a busy flag.
- Sits between decode (register addresses) and the ALU/writeback stage.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 4, register index width; depth NUM_REGS = 2**ADDR_WIDTH

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
writeEnable  input  1  write strobe for writeReg/dataIn
writeReg  input  ADDR_WIDTH  write register index
dataIn  input  DATA_WIDTH  write data
readRegA  input  ADDR_WIDTH  read port A index
readRegB  input  ADDR_WIDTH  read port B index
dataOutA  output  DATA_WIDTH  registered read data, port A
dataOutB  output  DATA_WIDTH  registered read data, port B
clearReq  input  1  single-cycle request to start bulk clear
busy  output  1  high while clear sweep in progress

Behaviour:
- Reset:
  - Takes effect only at a rising edge of clk, and overrides every other input.
  - After that edge: all registers = 0, dataOutA = dataOutB = 0, busy = 0, FSM = IDLE, sweep counter = 0.
- Write:
  - Applies at an edge with writeEnable=1 and FSM=IDLE: registers[writeReg] <= dataIn.
  - Any write while busy=1 is discarded silently. No queueing.
- Read:
  - Latency is 1 cycle. At each non-reset edge, dataOutX <= registers[readRegX].
  - Both ports are fully independent. Both may address the same register, including writeReg.
- Forwarding:
  - Applies at an edge with a valid write (writeEnable=1, IDLE) and readRegX == writeReg: dataOutX <= dataIn, not the old contents.
  - No forwarding during CLEAR.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: on an edge with clearReq=1. Sweep counter <= 0 and busy <= 1.
  - CLEAR: each edge zeroes registers[counter], then counter increments.
  - CLEAR -> IDLE: on the edge that zeroes index NUM_REGS-1. busy <= 0 at that same edge.
  - busy is high for exactly NUM_REGS cycles.
  - clearReq while in CLEAR is ignored (no restart, no extension).
- Simultaneous clearReq and valid write in IDLE: the write is performed at that edge, and the sweep later zeroes that register as well.
- Reads during CLEAR:
  - Return current contents: 0 for entries already swept, old value for entries not yet swept.
  - A read of the index being swept at that same edge returns the pre-clear value.
- Reset during CLEAR aborts the sweep. All registers are zeroed at once and FSM = IDLE, busy = 0. A write is accepted on the very next edge.
- Counter is ADDR_WIDTH bits. Its wrap at NUM_REGS-1 coincides with the CLEAR -> IDLE transition. No out-of-range index exists.

Optional Feature:
REGISTER_FILE_ZERO_REG_EN
- Defined:
  - Register 0 is hardwired to zero. Writes with writeReg=0 are discarded.
  - Reads of index 0 always return 0, and forwarding to index 0 is suppressed.
  - The clear sweep still takes NUM_REGS cycles.
- Undefined: register 0 is an ordinary storage register.

Test Plan:
1. Write all 16 regs with 0xFFFFFFFF, then hold reset=1 for one edge -> every register, dataOutA and dataOutB read 0, busy=0.
2. Write reg i = 0xA5A50000+i for i=0..15, then drive readRegA=i, readRegB=15-i -> after one edge dataOutA=0xA5A50000+i, dataOutB=0xA5A50000+(15-i).
3. Reg 5 = 0x11111111. Same edge: writeEnable=1, writeReg=5, dataIn=0xDEADBEEF, readRegA=5, readRegB=5 -> both outputs 0xDEADBEEF after that edge (forwarded); reg 5 = 0xDEADBEEF.
4. Fill with 0xFFFFFFFF, pulse clearReq one cycle:
   - busy is high exactly 16 cycles.
   - A write of 0x12345678 to reg 3 at cycle 8 of busy is dropped.
   - Reading reg 15 at busy cycle 10 returns 0xFFFFFFFF.
   - After busy falls, all registers read 0.
5. Start clear, assert reset at busy cycle 5 -> next edge busy=0, all regs 0. A write of 0xCAFEF00D to reg 9 on the following edge reads back 0xCAFEF00D.
6. Write 0x12345678 to reg 0 and read it back -> with REGISTER_FILE_ZERO_REG_EN reads 0, including on the forwarding edge; without it reads 0x12345678.
